// File: rtl/dec_num_parser_pkg.sv
// dec_num_parser_pkg
//   Shared definitions for the streaming decimal-number parser: FSM state
//   encoding, ASCII character constants, and the saturating digit-count helper.
package dec_num_parser_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;  // no number in progress
  localparam logic [1:0] ST_SIGN = 2'd1;  // lone '-' seen
  localparam logic [1:0] ST_NUM  = 2'd2;  // at least one digit seen
  localparam logic [1:0] ST_EMIT = 2'd3;  // result held for the consumer

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_SIGN = ST_SIGN,
    S_NUM  = ST_NUM,
    S_EMIT = ST_EMIT
  } state_t;

  // ASCII constants
  localparam logic [7:0] CH_0     = 8'h30;  // "0"
  localparam logic [7:0] CH_9     = 8'h39;  // "9"
  localparam logic [7:0] CH_MINUS = 8'h2D;  // "-"

  // Digit counter ceiling
  localparam logic [7:0] NDIG_MAX = 8'd255;

  // Increment a digit count, holding at NDIG_MAX
  function automatic logic [7:0] ndig_inc(input logic [7:0] n);
    if (n == NDIG_MAX) begin
      return n;
    end else begin
      return n + 8'd1;
    end
  endfunction

endpackage

// File: rtl/dec_num_parser_char_class.sv
// char_class
//   Combinational ASCII character classifier for the decimal-number parser.
// Ports:
//   in_char  - ASCII character under test
//   is_digit - in_char is "0".."9"
//   is_minus - in_char is "-"
//   digit    - numeric value of in_char (meaningful only when is_digit)
module char_class
  import dec_num_parser_pkg::*;
(
  input  logic [7:0] in_char,
  output logic       is_digit,
  output logic       is_minus,
  output logic [3:0] digit
);

  assign is_digit = (in_char >= CH_0) && (in_char <= CH_9);
  assign is_minus = (in_char == CH_MINUS);
  // "0" is 8'h30, so for digit characters the low nibble already equals
  // in_char - "0"; no subtractor is needed.
  assign digit    = in_char[3:0];

endmodule

// File: rtl/dec_num_parser.sv
// dec_num_parser
//   Streaming ASCII decimal-number parser. Accepts one character per cycle,
//   accumulates a run of decimal digits (optionally preceded by '-') into a
//   WIDTH-bit integer and presents the finished number when a non-digit
//   terminator arrives. The result is held until the consumer accepts it.
// Parameters:
//   WIDTH  - result width in bits (>= 4)
//   SIGNED - 1: one leading '-' is accepted and the result is negated
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_valid / in_ready - character handshake, in_char is the ASCII byte
//   out_valid/out_ready - result handshake
//   out_value           - parsed value (two's complement when negative)
//   out_ndig            - number of digits consumed, saturating at 255
//   out_ovf             - magnitude did not fit in WIDTH bits
module dec_num_parser
  import dec_num_parser_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [7:0]       out_ndig,
  output logic             out_ovf
);

  localparam logic [WIDTH+3:0] TEN_W4 = (WIDTH+4)'(10);

  // Registered state
  state_t           state_r;
  logic [WIDTH-1:0] acc_r;
  logic [7:0]       ndig_r;
  logic             neg_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_value_r;
  logic [7:0]       out_ndig_r;
  logic             out_ovf_r;

  // Next-state values
  state_t           state_n;
  logic [WIDTH-1:0] acc_n;
  logic [7:0]       ndig_n;
  logic             neg_n;
  logic             ovf_n;
  logic             out_valid_n;
  logic [WIDTH-1:0] out_value_n;
  logic [7:0]       out_ndig_n;
  logic             out_ovf_n;

  // Character classification and datapath helpers
  logic             is_digit_s;
  logic             is_minus_s;
  logic [3:0]       digit_s;
  logic             minus_ok_s;
  logic             accept_s;
  logic [WIDTH+3:0] mac_s;
  logic [WIDTH-1:0] neg_acc_s;

  char_class u_char_class (
    .in_char  (in_char),
    .is_digit (is_digit_s),
    .is_minus (is_minus_s),
    .digit    (digit_s)
  );

  // '-' only has meaning as a sign when the parser is built signed
  assign minus_ok_s = is_minus_s && (SIGNED != 1'b0);

  assign in_ready = (state_r != S_EMIT);
  assign accept_s = in_valid && (state_r != S_EMIT);

  // acc*10 + digit never exceeds 10*2^WIDTH, so four guard bits catch every
  // overflow; any set guard bit means the exact value is >= 2^WIDTH.
  assign mac_s     = ({4'b0000, acc_r} * TEN_W4) + (WIDTH+4)'(digit_s);
  assign neg_acc_s = (~acc_r) + WIDTH'(1);

  // Next-state, accumulator and output-register computation
  always_comb begin
    state_n     = state_r;
    acc_n       = acc_r;
    ndig_n      = ndig_r;
    neg_n       = neg_r;
    ovf_n       = ovf_r;
    out_valid_n = out_valid_r;
    out_value_n = out_value_r;
    out_ndig_n  = out_ndig_r;
    out_ovf_n   = out_ovf_r;

    case (state_r)
      S_IDLE: begin
        if (accept_s && is_digit_s) begin
          state_n = S_NUM;
          acc_n   = WIDTH'(digit_s);
          ndig_n  = 8'd1;
          neg_n   = 1'b0;
          ovf_n   = 1'b0;
        end else if (accept_s && minus_ok_s) begin
          state_n = S_SIGN;
          neg_n   = 1'b1;
        end else begin
          // other characters are discarded
          state_n = S_IDLE;
        end
      end

      S_SIGN: begin
        if (accept_s && is_digit_s) begin
          state_n = S_NUM;
          acc_n   = WIDTH'(digit_s);
          ndig_n  = 8'd1;
          ovf_n   = 1'b0;
        end else if (accept_s && minus_ok_s) begin
          state_n = S_SIGN;
        end else if (accept_s) begin
          // sign without digits: abandon silently
          state_n = S_IDLE;
          neg_n   = 1'b0;
        end else begin
          state_n = S_SIGN;
        end
      end

      S_NUM: begin
        if (accept_s && is_digit_s) begin
          acc_n  = mac_s[WIDTH-1:0];
          ndig_n = ndig_inc(ndig_r);
          ovf_n  = ovf_r || (mac_s[WIDTH+3:WIDTH] != 4'b0000);
        end else if (accept_s) begin
          // terminator is consumed here and latched into the output registers
          state_n     = S_EMIT;
          out_valid_n = 1'b1;
          out_value_n = neg_r ? neg_acc_s : acc_r;
          out_ndig_n  = ndig_r;
          out_ovf_n   = ovf_r;
        end else begin
          state_n = S_NUM;
        end
      end

      S_EMIT: begin
        if (out_ready) begin
          state_n     = S_IDLE;
          out_valid_n = 1'b0;
          neg_n       = 1'b0;
        end else begin
          state_n = S_EMIT;
        end
      end

      default: begin
        state_n     = S_IDLE;
        out_valid_n = 1'b0;
      end
    endcase
  end

  // State, accumulator and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      acc_r       <= '0;
      ndig_r      <= 8'd0;
      neg_r       <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_value_r <= '0;
      out_ndig_r  <= 8'd0;
      out_ovf_r   <= 1'b0;
    end else begin
      state_r     <= state_n;
      acc_r       <= acc_n;
      ndig_r      <= ndig_n;
      neg_r       <= neg_n;
      ovf_r       <= ovf_n;
      out_valid_r <= out_valid_n;
      out_value_r <= out_value_n;
      out_ndig_r  <= out_ndig_n;
      out_ovf_r   <= out_ovf_n;
    end
  end

  assign out_valid = out_valid_r;
  assign out_value = out_value_r;
  assign out_ndig  = out_ndig_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_dec_num_parser.sv
// tb_dec_num_parser
//   Self-checking bench for dec_num_parser (WIDTH=32, SIGNED=1). Expected
//   results are queued as each number is streamed and compared when the
//   parser hands a result over.
module tb_dec_num_parser;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_value;
  logic [7:0]  out_ndig;
  logic        out_ovf;

  int checks;
  int failures;

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  ndig;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];

  dec_num_parser #(.WIDTH(32), .SIGNED(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_ndig  (out_ndig),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] value, input logic [7:0] ndig, input logic ovf);
    exp_t e;
    e.value = value;
    e.ndig  = ndig;
    e.ovf   = ovf;
    sb_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_char(input logic [7:0] c);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_char  = c;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  // Stream a string ending in a terminator and check out_valid one cycle later.
  task automatic send_num(input string s);
    send_str(s);
    @(negedge clk);
    chk("out_valid_latency", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare on each completed output handshake
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", {32'd0, out_value}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_value", {32'd0, out_value}, {32'd0, e.value});
        chk("out_ndig",  {56'd0, out_ndig},  {56'd0, e.ndig});
        chk("out_ovf",   {63'd0, out_ovf},   {63'd0, e.ovf});
      end
    end
  end

  initial begin
    int n;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_value", {32'd0, out_value}, 64'd0);
    chk("rst_out_ndig",  {56'd0, out_ndig},  64'd0);
    chk("rst_out_ovf",   {63'd0, out_ovf},   64'd0);
    @(posedge clk);
    #1;

    exp_push(32'd123, 8'd3, 1'b0);
    send_num("123 ");

    exp_push(32'hFFFFFFD3, 8'd2, 1'b0);
    send_num("-45,");

    exp_push(32'hFFFFFFF9, 8'd1, 1'b0);
    send_num("--7x");

    exp_push(32'd9, 8'd1, 1'b0);
    send_num("-a9 ");

    exp_push(32'h00000000, 8'd10, 1'b1);
    send_num("4294967296\n");

    exp_push(32'hFFFFFFFF, 8'd10, 1'b0);
    send_num("4294967295\n");

    // back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    exp_push(32'd5, 8'd1, 1'b0);
    send_str("5 ");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_in_ready",  {63'd0, in_ready},  64'd0);
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_out_value", {32'd0, out_value}, 64'd5);
      chk("hold_out_ndig",  {56'd0, out_ndig},  64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_in_ready",  {63'd0, in_ready},  64'd1);
    chk("post_hs_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    exp_push(32'd6, 8'd1, 1'b0);
    send_num("6 ");

    // idle gaps inside a digit run
    exp_push(32'd98, 8'd2, 1'b0);
    send_char(8'h39);
    repeat (3) @(posedge clk);
    #1;
    send_num("8 ");

    // leading garbage is discarded
    exp_push(32'd12, 8'd2, 1'b0);
    send_num("ab12;");

    // digit count saturation
    for (int k = 0; k < 260; k++) send_char(8'h30);
    exp_push(32'd0, 8'd255, 1'b0);
    send_num(" ");

    // reset mid-number discards the partial value
    send_str("56");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready",  {63'd0, in_ready},  64'd1);
    @(posedge clk);
    #1;
    exp_push(32'd7, 8'd1, 1'b0);
    send_num("7 ");

    // drain scoreboard
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      n++;
      @(posedge clk);
    end
    chk("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec_num_parser.md
# dec_num_parser

Streaming ASCII decimal-number parser: consumes one character per cycle over a valid/ready handshake, accumulates consecutive decimal digits (with optional leading minus sign) into a WIDTH-bit integer, and emits the completed number with digit count and overflow flag when a non-digit terminator arrives. Sits between a character source (UART RX / console input buffer) and datapath logic that needs parsed operands; generalises single-character digit classification into multi-character, width-parametrised number extraction.

## Interface
- WIDTH, 32, result width in bits (≥ 4)
- SIGNED, 1, 1 = accept one leading '-' and emit two's-complement result; 0 = '-' is an ordinary terminator/non-digit
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_char is valid this cycle
- in_char  input  8  ASCII character
- in_ready  output  1  parser accepts in_char this cycle
- out_valid  output  1  parsed number available
- out_ready  input  1  consumer accepts the number
- out_value  output  WIDTH  parsed value (two's complement if negative)
- out_ndig  output  8  digits consumed, saturates at 255
- out_ovf  output  1  magnitude exceeded WIDTH bits during accumulation

## Operation
- Char accepted iff in_valid && in_ready. Digit = "0".."9" inclusive; digit value = in_char − "0".
- States: IDLE (no number in progress), SIGN (lone '-' seen, SIGNED=1 only), NUM (≥1 digit seen), EMIT (result held).
- IDLE: digit → NUM, acc = digit, ndig = 1, neg = 0, ovf = 0. '-' (SIGNED) → SIGN, neg = 1. Other → stay IDLE, char discarded.
- SIGN: digit → NUM as above but neg kept 1. '-' → stay SIGN. Other → IDLE, neg cleared, nothing emitted.
- NUM: digit → acc = acc·10 + digit (low WIDTH bits kept), ndig += 1 saturating at 255; ovf set sticky if the exact result ≥ 2^WIDTH. Non-digit (including '-') → EMIT; terminator is consumed, not reprocessed.
- EMIT: out_valid = 1; out_value = neg ? −acc : acc (mod 2^WIDTH); in_ready = 0. On out_ready → IDLE.
- Overflow check uses a WIDTH+4-bit intermediate; ovf does not alter out_value beyond truncation.
- Reset: state IDLE, acc 0, ndig 0, neg 0, ovf 0; outputs out_valid 0, out_value 0, out_ndig 0, out_ovf 0, in_ready 1. Reset mid-number discards the partial value; reset during EMIT drops the pending result.

## Timing
- in_ready = (state != EMIT), combinational from state only; never depends on in_valid.
- Terminator accepted at edge t → out_valid high from t+1; out_value/ndig/ovf stable while out_valid && !out_ready.
- Handshake completes at edge where out_valid && out_ready; out_valid low and in_ready high next cycle (one-cycle bubble, no input accepted during EMIT).
- Throughput: one digit per cycle; number of N digits + terminator → result N+1 cycles after first digit accepted.
- in_valid low cycles: state and accumulators hold.
- No end-of-stream flush: a number is emitted only on a terminator character.

## Structure
- Shared package: state encoding (IDLE/SIGN/NUM/EMIT as 2-bit localparams), ASCII constants CH_0 "0", CH_9 "9", CH_MINUS "-", NDIG_MAX 255.
- One sub-module, char_class: combinational, in_char → is_digit, is_minus, digit[3:0]. Parser FSM and accumulator stay in dec_num_parser.

## Test plan
- Reset, then stream "123 " with out_ready=1 → one result: out_value 123, out_ndig 3, out_ovf 0, out_valid one cycle after space accepted.
- SIGNED=1, stream "-45," → out_value 32'hFFFFFFD3 (−45), ndig 2; stream "--7x" → −7; stream "-a9 " → only 9 emitted.
- WIDTH=32, stream "4294967296\n" → out_ovf 1, out_value 0, ndig 10; "4294967295\n" → ovf 0, value 32'hFFFFFFFF.
- Hold out_ready=0 for 5 cycles after result → in_ready 0, outputs stable all 5 cycles; raise out_ready → in_ready 1 next cycle, next char accepted.
- Insert in_valid=0 gaps inside "9 0 8" style digit runs ("98" with 3 idle cycles between) → value 98, ndig 2; leading garbage "ab12;" → 12.
- Assert reset after "56" accepted, then stream "7 " → out_value 7, ndig 1 (partial discarded).
